// File: rtl/debounce_fsm.sv
// Push-button debouncer: two-flop synchroniser feeding a four-state qualifier
// that emits a clean level plus registered one-cycle rise/fall pulses.
module debounce_fsm #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             s1_reg;
  logic             sw_s_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg    <= 1'b0;
      sw_s_reg  <= 1'b0;
      state_reg <= ZERO;
      cnt_reg   <= '0;
      db_level  <= 1'b0;
      db_rise   <= 1'b0;
      db_fall   <= 1'b0;
    end else begin
      s1_reg   <= sw;
      sw_s_reg <= s1_reg;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;

      case (state_reg)
        ZERO: begin
          db_level <= 1'b0;
          if (sw_s_reg) begin
            state_reg <= WAIT1;
            cnt_reg   <= CNT_LOAD;
          end
        end

        WAIT1: begin
          if (!sw_s_reg) begin
            state_reg <= ZERO;
          end else if (cnt_reg == '0) begin
            state_reg <= ONE;
            db_level  <= 1'b1;
            db_rise   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ONE: begin
          db_level <= 1'b1;
          if (!sw_s_reg) begin
            state_reg <= WAIT0;
            cnt_reg   <= CNT_LOAD;
          end
        end

        WAIT0: begin
          // a high sample aborts the release; db_level was never dropped
          if (sw_s_reg) begin
            state_reg <= ONE;
          end else if (cnt_reg == '0) begin
            state_reg <= ZERO;
            db_level  <= 1'b0;
            db_fall   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= ZERO;
          cnt_reg   <= '0;
          db_level  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Randomised and directed bench for debounce_fsm (DB_CYCLES=4 and 1) against a
// run-length reference model: a change is accepted after DB_CYCLES+1 differing samples.
module tb_debounce_fsm;

  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw    = 1'b0;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state, index 0 -> DB_CYCLES=D, index 1 -> DB_CYCLES=1
  int dv [2] = '{D, 1};
  bit m_s1 [2];
  bit m_sws [2];
  bit m_lvl [2];
  bit m_rise [2];
  bit m_fall [2];
  int m_run [2];

  // per-window observations of instance 0
  int n_rise, n_fall, first_rise, first_fall, low_cnt, base;
  bit prev_rise [2];
  bit prev_fall [2];

  always #5 clk = ~clk;

  debounce_fsm #(.DB_CYCLES(D)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .db_level(lvl[0]), .db_rise(rise[0]), .db_fall(fall[0])
  );

  debounce_fsm #(.DB_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .db_level(lvl[1]), .db_rise(rise[1]), .db_fall(fall[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_s1[i] = 0; m_sws[i] = 0; m_lvl[i] = 0;
        m_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      end else begin
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (m_sws[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == dv[i] + 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) m_rise[i] = 1;
            else          m_fall[i] = 1;
          end
        end else begin
          m_run[i] = 0;
        end
        m_sws[i] = m_s1[i];
        m_s1[i]  = sw;
      end
    end
  endtask

  task automatic clear_window();
    n_rise = 0; n_fall = 0; first_rise = -1; first_fall = -1; low_cnt = 0;
    base = cyc;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("level%0d", i), int'(lvl[i]), int'(m_lvl[i]));
      check($sformatf("rise%0d", i), int'(rise[i]), int'(m_rise[i]));
      check($sformatf("fall%0d", i), int'(fall[i]), int'(m_fall[i]));
      check($sformatf("both%0d", i), int'(rise[i] & fall[i]), 0);
      check($sformatf("rise_twice%0d", i), int'(rise[i] & prev_rise[i]), 0);
      check($sformatf("fall_twice%0d", i), int'(fall[i] & prev_fall[i]), 0);
      prev_rise[i] = rise[i];
      prev_fall[i] = fall[i];
    end
    if (rise[0]) begin
      n_rise++;
      if (first_rise < 0) first_rise = cyc - base;
      $display("cyc %0d: db_rise (DB_CYCLES=%0d)", cyc, D);
    end
    if (fall[0]) begin
      n_fall++;
      if (first_fall < 0) first_fall = cyc - base;
      $display("cyc %0d: db_fall (DB_CYCLES=%0d)", cyc, D);
    end
    if (!lvl[0]) low_cnt++;
  endtask

  task automatic hold(input bit v, input int n);
    sw = v;
    repeat (n) step();
  endtask

  initial begin
    bit pat [5] = '{1, 0, 1, 1, 0};

    // reset held 3 cycles while sw toggles
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw = ~sw;
      step();
      check("rst_level", int'(lvl[0]), 0);
    end
    rst_n = 1'b1;
    hold(0, D + 6);

    // clean press: rise D+3 edges after first high sample
    clear_window();
    hold(1, D + 10);
    check("press_lat", first_rise, D + 3);
    check("press_cnt", n_rise, 1);
    check("press_level", int'(lvl[0]), 1);

    // clean release
    clear_window();
    hold(0, D + 10);
    check("release_lat", first_fall, D + 3);
    check("release_cnt", n_fall, 1);
    check("release_level", int'(lvl[0]), 0);

    // bounce 1,0,1,1,0 then steady 1: acceptance counts from the steady run
    clear_window();
    for (int i = 0; i < 5; i++) hold(pat[i], 1);
    hold(1, D + 10);
    check("bounce_lat", first_rise, 5 + D + 3);
    check("bounce_cnt", n_rise, 1);

    // single-cycle low glitch while high must not release
    clear_window();
    hold(0, 1);
    hold(1, D + 10);
    check("glitch_fall", n_fall, 0);
    check("glitch_low", low_cnt, 0);

    // reset during rise qualification, sw stays high through release
    hold(0, D + 10);
    clear_window();
    hold(1, 4);
    rst_n = 1'b0;
    step();
    check("midrst_level", int'(lvl[0]), 0);
    check("midrst_pre", n_rise, 0);
    rst_n = 1'b1;
    clear_window();
    hold(1, D + 10);
    check("midrst_lat", first_rise, D + 3);
    check("midrst_cnt", n_rise, 1);

    // randomised bouncing with long holds and occasional resets
    for (int seg = 0; seg < 600; seg++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(D, 3 * D) : $urandom_range(1, D);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 2));
        rst_n = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
